// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  // Controller states; encoding 2'd3 is unused and behaves as ST_RUN.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MCWAIT  = 2'd2
  } state_t;

  // Legal range of load-use stall cycles.
  localparam int unsigned LD_STALL_MIN = 1;
  localparam int unsigned LD_STALL_MAX = 3;

  // Width of the load-use down-counter (holds at most LD_STALL_MAX-1).
  localparam int unsigned LD_CNT_W = 2;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Load-use hazard detect: the load in EX writes a register the OF instruction reads.
module pipe_hazard_cmp (
  input  logic [3:0] of_rs1,
  input  logic       of_rs1_vld,
  input  logic [3:0] of_rs2,
  input  logic       of_rs2_vld,
  input  logic       ex_vld,
  input  logic [3:0] ex_rd,
  input  logic       ex_is_ld,
  output logic       hazard
);

  // Purely combinational source/destination match.
  always_comb begin
    hazard = ex_vld & ex_is_ld &
             ((of_rs1_vld & (of_rs1 == ex_rd)) |
              (of_rs2_vld & (of_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stalls, taken-branch flush, multi-cycle op wait.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LD_STALL = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       of_rs1,
  input  logic             of_rs1_vld,
  input  logic [3:0]       of_rs2,
  input  logic             of_rs2_vld,
  input  logic             ex_vld,
  input  logic [3:0]       ex_rd,
  input  logic             ex_is_ld,
  input  logic             ex_br_taken,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  output logic             pc_en,
  output logic             ifof_en,
  output logic             ifof_flush,
  output logic             ofex_en,
  output logic             ofex_bubble,
  output logic             exma_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  if (LD_STALL < LD_STALL_MIN || LD_STALL > LD_STALL_MAX) begin : g_bad_ld_stall
    $error("pipe_ctrl: LD_STALL out of legal range");
  end

  state_t              state_q, state_d;
  logic [LD_CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic                hazard;

  pipe_hazard_cmp u_hazard (
    .of_rs1     (of_rs1),
    .of_rs1_vld (of_rs1_vld),
    .of_rs2     (of_rs2),
    .of_rs2_vld (of_rs2_vld),
    .ex_vld     (ex_vld),
    .ex_rd      (ex_rd),
    .ex_is_ld   (ex_is_ld),
    .hazard     (hazard)
  );

  assign state = state_q;

  // Next state and same-cycle control outputs; reset forces the RUN defaults.
  always_comb begin
    pc_en       = 1'b1;
    ifof_en     = 1'b1;
    ifof_flush  = 1'b0;
    ofex_en     = 1'b1;
    ofex_bubble = 1'b0;
    exma_bubble = 1'b0;
    state_d     = ST_RUN;
    ld_cnt_d    = ld_cnt_q;
    if (!rst) begin
      case (state_q)
        ST_LDSTALL: begin
          pc_en       = 1'b0;
          ifof_en     = 1'b0;
          ofex_bubble = 1'b1;
          ld_cnt_d    = ld_cnt_q - LD_CNT_W'(1);
          state_d     = (ld_cnt_q == LD_CNT_W'(1)) ? ST_RUN : ST_LDSTALL;
        end
        ST_MCWAIT: begin
          if (!mc_done) begin
            pc_en       = 1'b0;
            ifof_en     = 1'b0;
            ofex_en     = 1'b0;
            exma_bubble = 1'b1;
            state_d     = ST_MCWAIT;
          end
        end
        default: begin
          if (ex_br_taken) begin
            ifof_flush  = 1'b1;
            ofex_bubble = 1'b1;
          end else if (ex_vld && ex_mc_start && !mc_done) begin
            pc_en       = 1'b0;
            ifof_en     = 1'b0;
            ofex_en     = 1'b0;
            exma_bubble = 1'b1;
            state_d     = ST_MCWAIT;
          end else if (hazard) begin
            pc_en       = 1'b0;
            ifof_en     = 1'b0;
            ofex_bubble = 1'b1;
            // The RUN cycle itself is the first stall cycle.
            if (LD_STALL > 1) begin
              state_d  = ST_LDSTALL;
              ld_cnt_d = LD_CNT_W'(LD_STALL - 1);
            end
          end
        end
      endcase
    end
  end

  // State and load-use counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      ld_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
